// File: rtl/butterfly_pipe_if.sv
// rtl/butterfly_pipe_if.sv - stream and status bundle for the radix-2 butterfly pipe
//
// Parameters: W (data component bits), TW (twiddle component bits).
// Input side : in_valid/in_ready handshake, a_in, b_in, twiddle ({re, im}), mode, scale.
// Output side: out_valid/out_ready handshake, a_out, b_out ({re, im}).
// Status     : ovf (sticky saturation flag), ovf_clr (synchronous clear of ovf).
// master drives beats into the butterfly and takes results; slave is the butterfly.
interface butterfly_pipe_if #(
    parameter int W  = 16,
    parameter int TW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [2*W-1:0]    a_in;
    logic [2*W-1:0]    b_in;
    logic [2*TW-1:0]   twiddle;
    logic              mode;
    logic              scale;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    a_out;
    logic [2*W-1:0]    b_out;
    logic              ovf;
    logic              ovf_clr;

    modport master (
        output in_valid, a_in, b_in, twiddle, mode, scale, out_ready, ovf_clr,
        input  in_ready, out_valid, a_out, b_out, ovf
    );

    modport slave (
        input  in_valid, a_in, b_in, twiddle, mode, scale, out_ready, ovf_clr,
        output in_ready, out_valid, a_out, b_out, ovf
    );
endinterface

// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - 4-stage pipelined radix-2 complex butterfly (DIT/DIF, scale, sat/wrap)
//
// Ports: clk (rising edge), clr (asynchronous active-high reset),
//        bus (butterfly_pipe_if.slave: input beat, output beat, ovf status).
// Optional feature macro: BUTTERFLY_SAT_EN - when defined, results clamp to the W-bit
// signed range and ovf records saturation; otherwise results wrap and ovf is 0.
// Stages: S1 input regs (+ DIF sum/difference), S2 four real products,
//         S3 product combine and half-up rounding, S4 add/sub, scale, width reduction.
module butterfly_pipe #(
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic            clk,
    input  logic            clr,
    butterfly_pipe_if.slave bus
);
    localparam int PW = W + 1 + TW;
    localparam int CW = PW + 1;
    // Rounding constant 2^(TW-2): half an LSB of the Q1.(TW-1) product.
    localparam logic signed [CW-1:0] RND = {{(W + 3){1'b0}}, 1'b1, {(TW - 2){1'b0}}};

    logic adv;

    logic signed [W-1:0]  a_re, a_im, b_re, b_im;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [W:0]    sum_re, sum_im, dif_re, dif_im;

    logic                 s1_valid, s1_mode, s1_scale;
    logic signed [W-1:0]  s1_a_re, s1_a_im;
    logic signed [W:0]    s1_sum_re, s1_sum_im, s1_op_re, s1_op_im;
    logic signed [TW-1:0] s1_w_re, s1_w_im;

    logic                 s2_valid, s2_mode, s2_scale;
    logic signed [W-1:0]  s2_a_re, s2_a_im;
    logic signed [W:0]    s2_sum_re, s2_sum_im;
    logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

    logic signed [CW-1:0] p_re_full, p_im_full;

    logic                 s3_valid, s3_mode, s3_scale;
    logic signed [W-1:0]  s3_a_re, s3_a_im;
    logic signed [W:0]    s3_sum_re, s3_sum_im;
    logic signed [W+1:0]  s3_p_re, s3_p_im;

    logic signed [W+1:0]  pa_re, pa_im, pb_re, pb_im;
    logic signed [W+2:0]  xa_re, xa_im, xb_re, xb_im;
    // Reduced component, MSB is the "this component saturated" flag.
    logic [W:0]           r_a_re, r_a_im, r_b_re, r_b_im;

    logic                 s4_valid;
    logic [2*W-1:0]       s4_a, s4_b;

    // Optional half-up divide by two, widened so x+1 cannot overflow.
    function automatic logic signed [W+2:0] half(input logic signed [W+1:0] x, input logic s);
        logic signed [W+2:0] t;
        t = (W + 3)'(x);
        half = s ? ((t + (W + 3)'(1)) >>> 1) : t;
    endfunction

    // The whole pipe freezes only when the output beat is not being taken.
    assign adv          = !(s4_valid && !bus.out_ready);
    assign bus.in_ready = adv;
    assign bus.out_valid = s4_valid;
    assign bus.a_out    = s4_a;
    assign bus.b_out    = s4_b;

    assign a_re = bus.a_in[2*W-1:W];
    assign a_im = bus.a_in[W-1:0];
    assign b_re = bus.b_in[2*W-1:W];
    assign b_im = bus.b_in[W-1:0];
    assign w_re = bus.twiddle[2*TW-1:TW];
    assign w_im = bus.twiddle[TW-1:0];

    assign sum_re = (W + 1)'(a_re) + (W + 1)'(b_re);
    assign sum_im = (W + 1)'(a_im) + (W + 1)'(b_im);
    assign dif_re = (W + 1)'(a_re) - (W + 1)'(b_re);
    assign dif_im = (W + 1)'(a_im) - (W + 1)'(b_im);

    // Complex multiply op*W with half-up rounding back to integer scale.
    assign p_re_full = CW'(s2_rr) - CW'(s2_ii) + RND;
    assign p_im_full = CW'(s2_ri) + CW'(s2_ir) + RND;

    always_comb begin
        if (s3_mode) begin
            pa_re = (W + 2)'(s3_sum_re);
            pa_im = (W + 2)'(s3_sum_im);
            pb_re = s3_p_re;
            pb_im = s3_p_im;
        end else begin
            pa_re = (W + 2)'(s3_a_re) + s3_p_re;
            pa_im = (W + 2)'(s3_a_im) + s3_p_im;
            pb_re = (W + 2)'(s3_a_re) - s3_p_re;
            pb_im = (W + 2)'(s3_a_im) - s3_p_im;
        end
        xa_re = half(pa_re, s3_scale);
        xa_im = half(pa_im, s3_scale);
        xb_re = half(pb_re, s3_scale);
        xb_im = half(pb_im, s3_scale);
    end

`ifdef BUTTERFLY_SAT_EN
    localparam logic signed [W+2:0] SMAX = {4'b0000, {(W - 1){1'b1}}};
    localparam logic signed [W+2:0] SMIN = {4'b1111, {(W - 1){1'b0}}};

    function automatic logic [W:0] clamp(input logic signed [W+2:0] x);
        if (x > SMAX)      clamp = {1'b1, SMAX[W-1:0]};
        else if (x < SMIN) clamp = {1'b1, SMIN[W-1:0]};
        else               clamp = {1'b0, x[W-1:0]};
    endfunction

    logic ovf_q;
    logic sat_any;

    assign r_a_re  = clamp(xa_re);
    assign r_a_im  = clamp(xa_im);
    assign r_b_re  = clamp(xb_re);
    assign r_b_im  = clamp(xb_im);
    assign sat_any = r_a_re[W] | r_a_im[W] | r_b_re[W] | r_b_im[W];

    // Set has priority over ovf_clr so a saturation in the clearing cycle is not lost.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                           ovf_q <= 1'b0;
        else if (adv && s3_valid && sat_any) ovf_q <= 1'b1;
        else if (bus.ovf_clr)              ovf_q <= 1'b0;
    end
    assign bus.ovf = ovf_q;
`else
    logic unused_wrap;

    assign r_a_re      = {1'b0, xa_re[W-1:0]};
    assign r_a_im      = {1'b0, xa_im[W-1:0]};
    assign r_b_re      = {1'b0, xb_re[W-1:0]};
    assign r_b_im      = {1'b0, xb_im[W-1:0]};
    assign unused_wrap = ^{bus.ovf_clr, r_a_re[W], r_a_im[W], r_b_re[W], r_b_im[W],
                           xa_re[W+2:W], xa_im[W+2:W], xb_re[W+2:W], xb_im[W+2:W]};
    assign bus.ovf     = 1'b0;
`endif

    logic unused_rnd;
    assign unused_rnd = ^{p_re_full[CW-1], p_re_full[TW-2:0], p_im_full[CW-1], p_im_full[TW-2:0]};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1_valid  <= 1'b0; s1_mode  <= 1'b0; s1_scale <= 1'b0;
            s1_a_re   <= '0;   s1_a_im  <= '0;
            s1_sum_re <= '0;   s1_sum_im <= '0;
            s1_op_re  <= '0;   s1_op_im <= '0;
            s1_w_re   <= '0;   s1_w_im  <= '0;
            s2_valid  <= 1'b0; s2_mode  <= 1'b0; s2_scale <= 1'b0;
            s2_a_re   <= '0;   s2_a_im  <= '0;
            s2_sum_re <= '0;   s2_sum_im <= '0;
            s2_rr     <= '0;   s2_ii    <= '0; s2_ri <= '0; s2_ir <= '0;
            s3_valid  <= 1'b0; s3_mode  <= 1'b0; s3_scale <= 1'b0;
            s3_a_re   <= '0;   s3_a_im  <= '0;
            s3_sum_re <= '0;   s3_sum_im <= '0;
            s3_p_re   <= '0;   s3_p_im  <= '0;
            s4_valid  <= 1'b0;
            s4_a      <= '0;   s4_b     <= '0;
        end else if (adv) begin
            // S1: DIF multiplies A-B, DIT multiplies B; pick the operand here.
            s1_valid  <= bus.in_valid;
            s1_mode   <= bus.mode;
            s1_scale  <= bus.scale;
            s1_a_re   <= a_re;
            s1_a_im   <= a_im;
            s1_sum_re <= sum_re;
            s1_sum_im <= sum_im;
            s1_op_re  <= bus.mode ? dif_re : (W + 1)'(b_re);
            s1_op_im  <= bus.mode ? dif_im : (W + 1)'(b_im);
            s1_w_re   <= w_re;
            s1_w_im   <= w_im;
            // S2
            s2_valid  <= s1_valid;
            s2_mode   <= s1_mode;
            s2_scale  <= s1_scale;
            s2_a_re   <= s1_a_re;
            s2_a_im   <= s1_a_im;
            s2_sum_re <= s1_sum_re;
            s2_sum_im <= s1_sum_im;
            s2_rr     <= PW'(s1_op_re) * PW'(s1_w_re);
            s2_ii     <= PW'(s1_op_im) * PW'(s1_w_im);
            s2_ri     <= PW'(s1_op_re) * PW'(s1_w_im);
            s2_ir     <= PW'(s1_op_im) * PW'(s1_w_re);
            // S3: keep bits [TW-1 +: W+2], i.e. arithmetic shift right by TW-1.
            s3_valid  <= s2_valid;
            s3_mode   <= s2_mode;
            s3_scale  <= s2_scale;
            s3_a_re   <= s2_a_re;
            s3_a_im   <= s2_a_im;
            s3_sum_re <= s2_sum_re;
            s3_sum_im <= s2_sum_im;
            s3_p_re   <= p_re_full[TW-1 +: W+2];
            s3_p_im   <= p_im_full[TW-1 +: W+2];
            // S4
            s4_valid  <= s3_valid;
            s4_a      <= {r_a_re[W-1:0], r_a_im[W-1:0]};
            s4_b      <= {r_b_re[W-1:0], r_b_im[W-1:0]};
        end
    end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - directed self-checking bench for butterfly_pipe (W=16, TW=16)
module tb_butterfly_pipe;
    logic clk;
    logic clr;
    int   errors;
    int   checks;

    butterfly_pipe_if #(.W(16), .TW(16)) bus ();

    butterfly_pipe #(.W(16), .TW(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cx(input int re, input int im);
        cx = {re[15:0], im[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated beat: checks acceptance, 4-cycle latency and both results.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] w, input logic m, input logic s,
                           input logic [31:0] ea, input logic [31:0] eb);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.twiddle  = w;
        bus.mode     = m;
        bus.scale    = s;
        bus.in_valid = 1'b1;
        #1 check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int n = 2; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "/latency"}, 64'(lat), 64'd4);
        check({tag, "/a_out"}, 64'(bus.a_out), 64'(ea));
        check({tag, "/b_out"}, 64'(bus.b_out), 64'(eb));
    endtask

    int accepted;
    int received;
    int ghost;
    logic [31:0] m1;

    initial begin
        errors        = 0;
        checks        = 0;
        clr           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.twiddle   = '0;
        bus.mode      = 1'b0;
        bus.scale     = 1'b0;
        bus.out_ready = 1'b1;
        bus.ovf_clr   = 1'b0;
        m1            = cx(-32768, 0);

        #2;
        check("rst/out_valid", 64'(bus.out_valid), 64'd0);
        check("rst/a_out", 64'(bus.a_out), 64'd0);
        check("rst/b_out", 64'(bus.b_out), 64'd0);
        check("rst/ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1 check("rst/in_ready", 64'(bus.in_ready), 64'd1);

        run_one("dit_m1", cx(1000, 0), cx(200, 0), m1, 1'b0, 1'b0, cx(800, 0), cx(1200, 0));
        run_one("dit_mj", cx(1000, 0), cx(200, 0), cx(0, -32768), 1'b0, 1'b0,
                cx(1000, -200), cx(1000, 200));
        run_one("dif_m1", cx(1000, 0), cx(200, 0), m1, 1'b1, 1'b0, cx(1200, 0), cx(-800, 0));
        run_one("dit_scale", cx(1000, 0), cx(200, 0), m1, 1'b0, 1'b1, cx(400, 0), cx(600, 0));

`ifdef BUTTERFLY_SAT_EN
        run_one("sat", cx(32000, 0), cx(32000, 0), m1, 1'b0, 1'b0, cx(0, 0), cx(32767, 0));
        check("sat/ovf_set", 64'(bus.ovf), 64'd1);
        repeat (3) @(negedge clk);
        check("sat/ovf_sticky", 64'(bus.ovf), 64'd1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check("sat/ovf_cleared", 64'(bus.ovf), 64'd0);
`else
        run_one("wrap", cx(32000, 0), cx(32000, 0), m1, 1'b0, 1'b0, cx(0, 0), cx(-1536, 0));
        check("wrap/ovf", 64'(bus.ovf), 64'd0);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check("wrap/ovf_after_clr", 64'(bus.ovf), 64'd0);
`endif

        // Beats k=1..8: A=(100k,k), B=(10k,0), W=-1 -> a=(90k,k), b=(110k,k).
        accepted = 0;
        received = 0;
        bus.mode    = 1'b0;
        bus.scale   = 1'b0;
        bus.twiddle = m1;
        for (int c = 1; c <= 40 && received < 8; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 6 && c <= 9);
            if (accepted < 8) begin
                bus.a_in     = cx(100 * (accepted + 1), accepted + 1);
                bus.b_in     = cx(10 * (accepted + 1), 0);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (c >= 6 && c <= 9) check("stall/in_ready", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid) begin
                check("seq/a_out", 64'(bus.a_out), 64'(cx(90 * (received + 1), received + 1)));
                check("seq/b_out", 64'(bus.b_out), 64'(cx(110 * (received + 1), received + 1)));
                if (bus.out_ready) received++;
            end
            if (bus.in_valid && bus.in_ready) accepted++;
        end
        check("seq/accepted", 64'(accepted), 64'd8);
        check("seq/received", 64'(received), 64'd8);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Three beats in flight, then a one-cycle clr.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.a_in     = cx(5000 + k, 0);
            bus.b_in     = cx(1, 0);
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr          = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ghost = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) ghost++;
        end
        check("clr/ghost_beats", 64'(ghost), 64'd0);
        run_one("post_clr", cx(1000, 0), cx(200, 0), m1, 1'b0, 1'b0, cx(800, 0), cx(1200, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
